// File: rtl/t_power2round_pkg.sv
// t_power2round_pkg: shared keygen constants and types for the t = A*s1 + s2 split stage.
package t_power2round_pkg;
    localparam int unsigned Q = 8380417;
    localparam int D = 13;
    localparam int N = 256;
    localparam int CNT_W = $clog2(N);
    localparam int COEF_W = 24;
    localparam int T1_W = 10;
    localparam int T0_W = 13;
    localparam int T1_WORD_W = 40;
    localparam int T1_PER_WORD = T1_WORD_W / T1_W;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/mod_add.sv
// mod_add: (a + b) mod Q for operands already reduced to [0,Q).
module mod_add import t_power2round_pkg::*; (
    input  logic [COEF_W-1:0] i_a,
    input  logic [COEF_W-1:0] i_b,
    output logic [COEF_W-1:0] o_sum
);
    logic [COEF_W:0] sum;
    always_comb begin
        sum = {1'b0, i_a} + {1'b0, i_b};
        o_sum = sum >= (COEF_W+1)'(Q) ? COEF_W'(sum - (COEF_W+1)'(Q)) : sum[COEF_W-1:0];
    end
endmodule

// File: rtl/t_power2round_p2r.sv
// power2round_unit: registered split of r in [0,Q) into t1 and packed t0 = 2^12 - r0.
module power2round_unit import t_power2round_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [COEF_W-1:0] i_r,
    output logic              o_valid,
    output logic [T1_W-1:0]   o_t1,
    output logic [T0_W-1:0]   o_t0
);
    localparam logic [D-1:0] HALF = D'(1 << (D-1));
    logic [D-1:0] lo;
    logic [COEF_W-D-1:0] hi;
    logic valid_d, valid_q;
    logic [T1_W-1:0] t1_d, t1_q;
    logic [T0_W-1:0] t0_d, t0_q;
    // 4096 - r0 wraps to the same 13-bit value whether or not lo was recentred
    always_comb begin
        lo = i_r[D-1:0];
        hi = i_r[COEF_W-1:D];
        valid_d = i_valid && !i_flush;
        t1_d = i_valid ? T1_W'(lo > HALF ? hi + 1'b1 : hi) : t1_q;
        t0_d = i_valid ? HALF - lo : t0_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            t1_q <= '0;
            t0_q <= '0;
        end else begin
            valid_q <= valid_d;
            t1_q <= t1_d;
            t0_q <= t0_d;
        end
    end
    assign o_valid = valid_q;
    assign o_t1 = t1_q;
    assign o_t0 = t0_q;
endmodule

// File: rtl/t_power2round.sv
// t_power2round: adds s2 to each accumulated A*s1 coefficient mod Q and splits it with
// Power2Round, emitting t1/t0 per coefficient and t1 packed four per 40-bit word.
module t_power2round import t_power2round_pkg::*; (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_res_valid,
    input  logic [COEF_W-1:0]    i_res_data,
    input  logic                 i_res_last,
    output logic [CNT_W-1:0]     o_s2_addr,
    input  logic [COEF_W-1:0]    i_s2_data,
    output logic                 o_t_valid,
    output logic [T1_W-1:0]      o_t1,
    output logic [T0_W-1:0]      o_t0,
    output logic                 o_t1w_valid,
    output logic [T1_WORD_W-1:0] o_t1w_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic v1_q, v1_d, v2_q, v2_d;
    logic [COEF_W-1:0] a_q, a_d, r_q, r_d, sum;
    logic [T1_WORD_W-1:0] sr_q, sr_d;
    logic [1:0] oc_q, oc_d;
    logic wv_q, wv_d;
    logic run, take, at_end;

    mod_add u_add (.i_a(a_q), .i_b(i_s2_data), .o_sum(sum));

    power2round_unit u_p2r (
        .clk(clk), .rst_n(rst_n), .i_flush(i_start), .i_valid(v2_q), .i_r(r_q),
        .o_valid(o_t_valid), .o_t1(o_t1), .o_t0(o_t0)
    );

    always_comb begin
        run = state_q == RUN;
        take = run && i_res_valid && !i_start;
        at_end = cnt_q == CNT_W'(N - 1);
        state_d = state_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (i_start) begin
            // a restart while active is itself an error; stray data beside a start is too
            state_d = RUN;
            cnt_d = '0;
            err_d = run || state_q == DRAIN || i_res_valid;
        end else if (take) begin
            cnt_d = cnt_q + 1'b1;
            if (i_res_last || at_end) begin
                state_d = DRAIN;
                err_d = err_q || !(i_res_last && at_end);
            end
        end else begin
            err_d = err_q || (i_res_valid && !run);
            if (state_q == DRAIN && !v1_q && !v2_q && !o_t_valid) state_d = DONE;
            if (state_q == DONE) state_d = IDLE;
        end
        v1_d = take;
        a_d = take ? i_res_data : a_q;
        v2_d = v1_q && !i_start;
        r_d = v1_q ? sum : r_q;
        sr_d = i_start ? '0 : o_t_valid ? {o_t1, sr_q[T1_WORD_W-1:T1_W]} : sr_q;
        oc_d = i_start ? '0 : oc_q + 2'(o_t_valid);
        wv_d = !i_start && o_t_valid && oc_q == 2'(T1_PER_WORD - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            err_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            a_q <= '0;
            r_q <= '0;
            sr_q <= '0;
            oc_q <= '0;
            wv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
            a_q <= a_d;
            r_q <= r_d;
            sr_q <= sr_d;
            oc_q <= oc_d;
            wv_q <= wv_d;
        end
    end

    assign o_s2_addr = cnt_q;
    assign o_busy = state_q == RUN || state_q == DRAIN;
    assign o_done = state_q == DONE;
    assign o_err = err_q;
    assign o_t1w_valid = wv_q;
    assign o_t1w_data = sr_q;
endmodule

// File: tb/tb_t_power2round.sv
// tb_t_power2round: directed and randomized polynomials checked against an arithmetic Power2Round model.
module tb_t_power2round;
    localparam int QM = 8380417;
    logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_res_valid = 1'b0, i_res_last = 1'b0;
    logic [23:0] i_res_data = '0, i_s2_data = '0;
    logic [7:0] o_s2_addr;
    logic o_t_valid, o_t1w_valid, o_busy, o_done, o_err;
    logic [9:0] o_t1;
    logic [12:0] o_t0;
    logic [39:0] o_t1w_data;
    int errors = 0, checks = 0, done_cnt = 0;
    int a_mem[256], s2_mem[256], t1_mem[256];
    int exp_t1[$], exp_t0[$], got_t1[$], got_t0[$];
    logic [39:0] exp_w[$], got_w[$];

    t_power2round dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_res_valid(i_res_valid),
        .i_res_data(i_res_data), .i_res_last(i_res_last), .o_s2_addr(o_s2_addr),
        .i_s2_data(i_s2_data), .o_t_valid(o_t_valid), .o_t1(o_t1), .o_t0(o_t0),
        .o_t1w_valid(o_t1w_valid), .o_t1w_data(o_t1w_data), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) i_s2_data <= 24'(s2_mem[o_s2_addr]);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int a, input int s, output int t1, output int t0);
        int r, r0;
        r = (a + s) % QM;
        r0 = r % 8192;
        if (r0 > 4096) r0 -= 8192;
        t1 = (r - r0) / 8192;
        t0 = 4096 - r0;
    endfunction

    always @(negedge clk) if (rst_n) begin
        if (o_t_valid) begin
            got_t1.push_back(int'(o_t1));
            got_t0.push_back(int'(o_t0));
            if (exp_t1.size() == 0) chk("t_unexpected", 64'(o_t_valid), 64'd0);
            else begin
                chk("t1", 64'(o_t1), 64'(exp_t1.pop_front()));
                chk("t0", 64'(o_t0), 64'(exp_t0.pop_front()));
            end
        end
        if (o_t1w_valid) begin
            got_w.push_back(o_t1w_data);
            if (exp_w.size() == 0) chk("w_unexpected", 64'(o_t1w_valid), 64'd0);
            else chk("t1w", 64'(o_t1w_data), 64'(exp_w.pop_front()));
        end
        if (o_done) begin
            done_cnt++;
            chk("busy_at_done", 64'(o_busy), 64'd0);
        end
    end

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = int'($urandom_range(QM - 1, 0));
            s2_mem[i] = int'($urandom_range(QM - 1, 0));
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        i_res_valid = 1'b0;
        i_res_last = 1'b0;
        i_res_data = 24'($urandom);
    endtask

    task automatic send(input int idx, input bit last);
        int t1, t0;
        logic [39:0] w;
        model(a_mem[idx], s2_mem[idx], t1, t0);
        t1_mem[idx] = t1;
        @(posedge clk); #1;
        i_res_valid = 1'b1;
        i_res_last = last;
        i_res_data = 24'(a_mem[idx]);
        exp_t1.push_back(t1);
        exp_t0.push_back(t0);
        if (idx % 4 == 3) begin
            w = '0;
            for (int j = 0; j < 4; j++) w = w | (40'(t1_mem[idx - 3 + j]) << (10 * j));
            exp_w.push_back(w);
        end
    endtask

    task automatic start_poly(input bit exp_err);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_res_valid = 1'b0;
        i_res_last = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        exp_t1.delete(); exp_t0.delete(); exp_w.delete();
        got_t1.delete(); got_t0.delete(); got_w.delete();
        chk("busy_after_start", 64'(o_busy), 64'd1);
        chk("addr_after_start", 64'(o_s2_addr), 64'd0);
        chk("err_after_start", 64'(o_err), 64'(exp_err));
    endtask

    task automatic body(input bit gapped, input int last_at, input bit exp_err, input int exp_words);
        int n, d0, g;
        n = last_at < 0 ? 256 : last_at + 1;
        for (int i = 0; i < n; i++) begin
            g = gapped ? int'($urandom_range(2, 0)) : 0;
            for (int k = 0; k < g; k++) idle();
            send(i, i == last_at);
        end
        idle();
        d0 = done_cnt;
        for (int k = 0; k < 40 && done_cnt == d0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("out_count", 64'(got_t1.size()), 64'(n));
        chk("word_count", 64'(got_w.size()), 64'(exp_words));
        chk("left_over", 64'(exp_t1.size() + exp_w.size()), 64'd0);
        chk("err_end", 64'(o_err), 64'(exp_err));
        chk("busy_idle", 64'(o_busy), 64'd0);
    endtask

    initial begin
        fill_rand();
        #12;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_tv", 64'(o_t_valid), 64'd0);
        chk("rst_wv", 64'(o_t1w_valid), 64'd0);
        chk("rst_addr", 64'(o_s2_addr), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        a_mem[0] = 8191;    s2_mem[0] = 0;
        a_mem[1] = 4096;    s2_mem[1] = 0;
        a_mem[2] = QM - 1;  s2_mem[2] = 1;
        a_mem[3] = QM - 1;  s2_mem[3] = 0;
        for (int k = 1; k <= 4; k++) begin
            a_mem[3 + k] = 8192 * k;
            s2_mem[3 + k] = 0;
        end
        start_poly(1'b0);
        body(1'b0, 255, 1'b0, 64);
        chk("split_8191_t1", 64'(got_t1[0]), 64'd1);
        chk("split_8191_t0", 64'(got_t0[0]), 64'd4097);
        chk("split_4096_t1", 64'(got_t1[1]), 64'd0);
        chk("split_4096_t0", 64'(got_t0[1]), 64'd0);
        chk("wrap_zero_t1", 64'(got_t1[2]), 64'd0);
        chk("wrap_zero_t0", 64'(got_t0[2]), 64'd4096);
        chk("qm1_t1", 64'(got_t1[3]), 64'd1023);
        chk("qm1_t0", 64'(got_t0[3]), 64'd4096);
        chk("pack_1234", 64'(got_w[1]), 64'h0100300801);

        fill_rand();
        start_poly(1'b0);
        body(1'b1, 255, 1'b0, 64);

        fill_rand();
        start_poly(1'b0);
        body(1'b1, 100, 1'b1, 25);

        fill_rand();
        start_poly(1'b0);
        body(1'b0, -1, 1'b1, 64);

        @(posedge clk); #1 i_res_valid = 1'b1;
        @(posedge clk); #1 i_res_valid = 1'b0;
        chk("idle_valid_err", 64'(o_err), 64'd1);

        fill_rand();
        start_poly(1'b0);
        for (int i = 0; i < 20; i++) send(i, 1'b0);
        start_poly(1'b1);
        body(1'b0, 255, 1'b1, 64);

        fill_rand();
        start_poly(1'b0);
        for (int i = 0; i < 50; i++) send(i, 1'b0);
        idle();
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(o_busy), 64'd0);
        chk("arst_tv", 64'(o_t_valid), 64'd0);
        chk("arst_t1", 64'(o_t1), 64'd0);
        chk("arst_t0", 64'(o_t0), 64'd0);
        chk("arst_wv", 64'(o_t1w_valid), 64'd0);
        chk("arst_wdata", 64'(o_t1w_data), 64'd0);
        chk("arst_addr", 64'(o_s2_addr), 64'd0);
        chk("arst_done_err", 64'({o_done, o_err}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        fill_rand();
        start_poly(1'b0);
        body(1'b1, 255, 1'b0, 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
